// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: registered clk_div level and last-cycle shift_en strobe,
// with a runtime divisor that only changes at period boundaries, pause and phase restart.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic             clk_div,
    output logic             shift_en,
    output logic [CNT_W-1:0] div_active,
    output logic             div_pending
);

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Divisors below 2 cannot produce both a high and a low phase.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             clk_div_q, clk_div_d;
    logic             shift_en_q, shift_en_d;

    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] next_div;
    logic             wrap;

    assign load_val = clamp_div(div_in);
    // A load on the boundary edge bypasses the pending slot.
    assign next_div = div_load ? load_val : (pend_q ? pval_q : div_q);
    assign wrap     = (cnt_q == div_q - ONE);

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pval_d     = pval_q;
        pend_d     = pend_q;
        clk_div_d  = clk_div_q;
        shift_en_d = 1'b0;
        if (restart) begin
            cnt_d     = '0;
            div_d     = next_div;
            pend_d    = 1'b0;
            clk_div_d = 1'b1;
        end else if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                div_d  = next_div;
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + ONE;
                if (div_load) begin
                    pval_d = load_val;
                    pend_d = 1'b1;
                end
            end
            // Outputs are decoded from the next state so they line up with the new count.
            clk_div_d  = (cnt_d < (div_d >> 1));
            shift_en_d = (cnt_d == div_d - ONE);
        end else if (div_load) begin
            pval_d = load_val;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= DIV_RST - ONE;
            div_q      <= DIV_RST;
            pval_q     <= '0;
            pend_q     <= 1'b0;
            clk_div_q  <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pval_q     <= pval_d;
            pend_q     <= pend_d;
            clk_div_q  <= clk_div_d;
            shift_en_q <= shift_en_d;
        end
    end

    assign clk_div     = clk_div_q;
    assign shift_en    = shift_en_q;
    assign div_active  = div_q;
    assign div_pending = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus a long random run against a period-level model.
module tb_clk_div_prog;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;

    logic             clk = 1'b0;
    logic             rst, en, restart, div_load;
    logic [CNT_W-1:0] div_in;
    logic             clk_div, shift_en, div_pending;
    logic [CNT_W-1:0] div_active;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the period, active divisor, queued divisor.
    int m_pos, m_div, m_pval;
    bit m_pend, m_clk, m_sh;

    clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .div_load   (div_load),
        .div_in     (div_in),
        .clk_div    (clk_div),
        .shift_en   (shift_en),
        .div_active (div_active),
        .div_pending(div_pending)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int chosen_div();
        if (div_load) return clampi(int'(div_in));
        if (m_pend) return m_pval;
        return m_div;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_pos = DEF - 1; m_div = DEF; m_pend = 0; m_pval = 0; m_clk = 0; m_sh = 0;
        end else if (restart) begin
            m_div = chosen_div(); m_pend = 0; m_pos = 0; m_clk = 1; m_sh = 0;
        end else if (en) begin
            if (m_pos + 1 == m_div) begin
                m_div = chosen_div(); m_pend = 0; m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
                if (div_load) begin m_pval = clampi(int'(div_in)); m_pend = 1; end
            end
            m_clk = (m_pos < m_div / 2);
            m_sh  = (m_pos == m_div - 1);
        end else begin
            m_sh = 0;
            if (div_load) begin m_pval = clampi(int'(div_in)); m_pend = 1; end
        end
    endtask

    // One rising edge; model follows the same inputs; returns at the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; restart = 0; div_load = 0; div_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({clk_div, shift_en, div_active, div_pending} !== {1'b0, 1'b0, 8'd4, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got clk=%0b sh=%0b div=%0d pend=%0b want 0 0 4 0",
                     clk_div, shift_en, div_active, div_pending);
        end
    endtask

    task automatic test_default_pattern();
        do_reset();
        en = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({clk_div, shift_en, div_active} !== {((i % 4) < 2), ((i % 4) == 3), 8'd4}) begin
                failures++;
                $display("FAIL default_pattern cyc=%0d got clk=%0b sh=%0b div=%0d want %0b %0b 4",
                         i, clk_div, shift_en, div_active, (i % 4) < 2, (i % 4) == 3);
            end
        end
    endtask

    task automatic test_load_midperiod();
        do_reset();
        en = 1;
        tick(); tick();               // count now 1
        div_load = 1; div_in = 8'd6;
        tick();
        div_load = 0;
        checks++;
        if ({div_pending, div_active} !== {1'b1, 8'd4}) begin
            failures++;
            $display("FAIL load_mid_pending got pend=%0b div=%0d want 1 4", div_pending, div_active);
        end
        tick();                       // count 3, still old period
        checks++;
        if ({shift_en, div_pending} !== 2'b11) begin
            failures++;
            $display("FAIL load_mid_oldperiod got sh=%0b pend=%0b want 1 1", shift_en, div_pending);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({clk_div, shift_en, div_active, div_pending} !== {((i % 6) < 3), ((i % 6) == 5), 8'd6, 1'b0}) begin
                failures++;
                $display("FAIL load_mid_newperiod cyc=%0d got clk=%0b sh=%0b div=%0d pend=%0b",
                         i, clk_div, shift_en, div_active, div_pending);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        do_reset();
        en = 1;
        for (int i = 0; i < 4; i++) tick();   // count 3, next edge wraps
        div_load = 1; div_in = 8'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            div_load = 0;
            checks++;
            if ({clk_div, shift_en, div_active, div_pending} !== {((i % 5) < 2), ((i % 5) == 4), 8'd5, 1'b0}) begin
                failures++;
                $display("FAIL load_on_wrap cyc=%0d got clk=%0b sh=%0b div=%0d pend=%0b",
                         i, clk_div, shift_en, div_active, div_pending);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        en = 1;
        tick(); tick(); tick();      // count 2: clk low, no strobe yet
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({clk_div, shift_en} !== 2'b00) begin
                failures++;
                $display("FAIL pause_hold cyc=%0d got clk=%0b sh=%0b want 0 0", i, clk_div, shift_en);
            end
        end
        en = 1;
        tick();
        checks++;
        if ({clk_div, shift_en} !== 2'b01) begin
            failures++;
            $display("FAIL pause_resume got clk=%0b sh=%0b want 0 1", clk_div, shift_en);
        end
        en = 0;                      // drop enable on the strobe cycle: single pulse only
        tick();
        checks++;
        if ({clk_div, shift_en} !== 2'b00) begin
            failures++;
            $display("FAIL pause_on_strobe got clk=%0b sh=%0b want 0 0", clk_div, shift_en);
        end
        en = 1;
        tick();
        checks++;
        if ({clk_div, shift_en} !== 2'b10) begin
            failures++;
            $display("FAIL pause_wrap got clk=%0b sh=%0b want 1 0", clk_div, shift_en);
        end
    endtask

    task automatic test_restart_clamp();
        do_reset();
        en = 1;
        tick(); tick(); tick();
        restart = 1; div_load = 1; div_in = 8'd0;
        tick();
        restart = 0; div_load = 0;
        checks++;
        if ({clk_div, shift_en, div_active, div_pending} !== {1'b1, 1'b0, 8'd2, 1'b0}) begin
            failures++;
            $display("FAIL restart_clamp got clk=%0b sh=%0b div=%0d pend=%0b want 1 0 2 0",
                     clk_div, shift_en, div_active, div_pending);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({clk_div, shift_en} !== {(i % 2 == 1), (i % 2 == 0)}) begin
                failures++;
                $display("FAIL restart_pattern cyc=%0d got clk=%0b sh=%0b", i, clk_div, shift_en);
            end
        end
    endtask

    task automatic test_reset_midperiod();
        do_reset();
        en = 1;
        tick(); tick();
        div_load = 1; div_in = 8'd9;
        tick();
        div_load = 0;
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({clk_div, shift_en, div_active, div_pending} !== {1'b0, 1'b0, 8'd4, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got clk=%0b sh=%0b div=%0d pend=%0b want 0 0 4 0",
                     clk_div, shift_en, div_active, div_pending);
        end
        for (int i = 0; i < 8; i++) begin  // discarded pending value must not appear
            tick();
            checks++;
            if ({clk_div, div_active} !== {((i % 4) < 2), 8'd4}) begin
                failures++;
                $display("FAIL reset_mid_discard cyc=%0d got clk=%0b div=%0d", i, clk_div, div_active);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            restart  = ($urandom_range(0, 39) == 0);
            en       = ($urandom_range(0, 9) < 8);
            div_load = ($urandom_range(0, 11) == 0);
            div_in   = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 40));
            tick();
            checks++;
            if ({clk_div, shift_en, div_active, div_pending} !==
                {m_clk, m_sh, 8'(m_div), m_pend}) begin
                failures++;
                $display("FAIL random cyc=%0d got clk=%0b sh=%0b div=%0d pend=%0b want %0b %0b %0d %0b",
                         i, clk_div, shift_en, div_active, div_pending, m_clk, m_sh, m_div, m_pend);
            end
        end
    endtask

    initial begin
        idle_inputs();
        m_pos = 0; m_div = DEF; m_pval = 0; m_pend = 0; m_clk = 0; m_sh = 0;
        @(negedge clk);
        test_reset();
        test_default_pattern();
        test_load_midperiod();
        test_load_on_wrap();
        test_pause();
        test_restart_clamp();
        test_reset_midperiod();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable clock-enable divider that generates a divided clock-style output `clk_div` and a one-cycle `shift_en` strobe, which the serial shift datapaths consume. It generalises the fixed-ratio `clk_div` with:

- a parametrised counter width and runtime-loadable divisor applied glitch-free at period boundaries;
- a pause enable;
- a synchronous phase restart.

It runs entirely in the system clock domain: `clk_div` is a registered level, never used as a clock.

## Interface
- `CNT_W`, default 8: width of divisor and period counter.
- `DEFAULT_DIV`, default 4: divisor after reset. Must be in 2..2^CNT_W-1.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; low pauses the period counter.
- `restart`  in  1  synchronous phase restart; a new period starts on the next edge.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_in`  in  CNT_W  requested divisor D.
- `clk_div`  out  1  divided level, high for the first floor(D/2) cycles of each period.
- `shift_en`  out  1  one-cycle strobe during the last cycle of each period.
- `div_active`  out  CNT_W  divisor in effect for the current period.
- `div_pending`  out  1  a loaded divisor is waiting for the next period boundary.

## Operation
- **State:**
  - `cnt`: 0..D-1.
  - `div_reg`: the active D.
  - `pend_val`/`pend`: the queued divisor.
  - `clk_div` and `shift_en` are registered.
- **Clamp:** any `div_in` < 2 is stored as 2. No other range check.
- **Priority:** `rst` > `restart` > `en`.
- **Reset, one edge with `rst`=1:**
  - `cnt`=DEFAULT_DIV-1, `div_reg`=DEFAULT_DIV.
  - `pend`=0, `pend_val`=0.
  - `clk_div`=0, `shift_en`=0.
  - All other inputs are ignored that edge.
- **Enabled edge (`en`=1, `restart`=0):**
  - New cnt' = (cnt==D-1) ? 0 : cnt+1.
  - `clk_div` <= (cnt' < floor(D'/2)).
  - `shift_en` <= (cnt' == D'-1).
  - D' is the divisor for the new period. D' = D unless a wrap occurs.
- **Wrap (cnt==D-1 → 0):**
  - `div_reg` <= `div_in` if `div_load`=1 that edge (bypass), else `pend_val` if `pend`=1, else unchanged.
  - `pend` <= 0.
  - Outputs for cnt'=0 use the new D'.
- **Non-wrap `div_load`:** `pend_val` <= clamp(`div_in`), `pend` <= 1. A repeated load overwrites; the last write wins.
- **Disabled edge (`en`=0, `restart`=0):**
  - `cnt`, `div_reg` and `clk_div` hold.
  - `shift_en` <= 0.
  - `div_load` is still captured into pending, never applied.
- **Restart edge, regardless of `en`:**
  - `cnt`=0, `clk_div`=1, `shift_en`=0.
  - `div_reg` <= `div_in` if `div_load`, else `pend_val` if `pend`, else unchanged.
  - `pend` <= 0.
- **Output mapping:** `div_active` = `div_reg`; `div_pending` = `pend`.

## Timing
- **After reset:** the first edge with `en`=1 sets `clk_div`=1 (cnt=0). There is no `shift_en` before that.
- **Period:** exactly D enabled cycles. `clk_div` is high for floor(D/2) cycles and low for D-floor(D/2) cycles.
  - D=2: 1 high, 1 low.
  - D=5: 2 high, 3 low.
- **`shift_en`:** high exactly the cycle `cnt`==D-1, i.e. the cycle before `clk_div` rises. At most one pulse per period.
  - If `en` drops during that cycle, the pulse lasts one cycle only.
  - The wrap occurs at the next enabled edge with no second pulse.
- **Divisor change:** takes effect at the first cycle of the next period; the current period always completes with the old D.
  - `div_pending` rises the cycle after a non-wrap load.
  - `div_pending` falls the cycle after the wrap.
- **Mid-operation reset or restart:** the period is truncated immediately. No partial `shift_en` is issued.

## Test plan
- **Reset, then `en`=1 held, default D=4:** `clk_div` pattern 1,1,0,0 repeating; `shift_en` high on every 4th cycle, aligned with the second low cycle; `div_active`=4.
- **`div_in`=6 loaded at cnt=1 with D=4:**
  - `div_pending`=1 until the wrap.
  - The current period stays at 4 cycles.
  - The next period is 6 cycles (3 high, 3 low); `div_active`=6.
- **`div_in`=5 loaded exactly on the wrap edge:** the new period is immediately 5 cycles (2 high, 3 low); `div_pending` never asserts.
- **`en` low for 3 cycles at cnt=2 with D=4:**
  - `clk_div` holds 0 and `shift_en` stays 0.
  - On resume, `shift_en` fires one cycle later.
  - Total enabled cycles per period = 4.
- **`restart` with `div_load`=1, `div_in`=0, mid-period:**
  - The next cycle has `clk_div`=1, cnt=0 and `div_active`=2 (clamped).
  - Pattern 1,0 repeating, with `shift_en` on every low cycle.
- **`rst` asserted mid-period with `pend`=1:** outputs are 0 and `div_active`=DEFAULT_DIV, `div_pending`=0 the next cycle. The pending value is discarded.
